// File: rtl/vector_alu_sequencer_if.sv
// vector_alu_sequencer_if
//   Request / ALU / response bundle for vector_alu_sequencer.
//   slave  : sequencer side (accepts req, drives ALU, produces rsp)
//   master : issue-stage / ALU / consumer side
//   Signals:
//     req_valid/req_ready, req_op[1:0], req_a/req_b[LANES*WIDTH]
//     req_bcast (only when VSEC_BCAST_EN is defined)
//     alu_a/alu_b[WIDTH], alu_ctrl[1:0], alu_result[WIDTH], alu_flags[1:0] ({Z,N})
//     rsp_valid/rsp_ready, rsp_result[LANES*WIDTH], rsp_flags[1:0], rsp_err
//   Optional feature macro: VSEC_BCAST_EN
interface vector_alu_sequencer_if #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
);
  logic                   req_valid;
  logic                   req_ready;
  logic [1:0]             req_op;
  logic [LANES*WIDTH-1:0] req_a;
  logic [LANES*WIDTH-1:0] req_b;
`ifdef VSEC_BCAST_EN
  logic                   req_bcast;
`endif
  logic [WIDTH-1:0]       alu_a;
  logic [WIDTH-1:0]       alu_b;
  logic [1:0]             alu_ctrl;
  logic [WIDTH-1:0]       alu_result;
  logic [1:0]             alu_flags;
  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [LANES*WIDTH-1:0] rsp_result;
  logic [1:0]             rsp_flags;
  logic                   rsp_err;

  modport slave (
`ifdef VSEC_BCAST_EN
    input  req_bcast,
`endif
    input  req_valid, req_op, req_a, req_b,
    output req_ready,
    output alu_a, alu_b, alu_ctrl,
    input  alu_result, alu_flags,
    output rsp_valid, rsp_result, rsp_flags, rsp_err,
    input  rsp_ready
  );

  modport master (
`ifdef VSEC_BCAST_EN
    output req_bcast,
`endif
    output req_valid, req_op, req_a, req_b,
    input  req_ready,
    input  alu_a, alu_b, alu_ctrl,
    output alu_result, alu_flags,
    input  rsp_valid, rsp_result, rsp_flags, rsp_err,
    output rsp_ready
  );
endinterface

// File: rtl/vector_alu_sequencer.sv
// vector_alu_sequencer
//   Walks one packed vector op through a shared combinational scalar ALU,
//   one lane per cycle, then holds the packed result plus aggregate flags
//   until the consumer takes it.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset
//     bus    : vector_alu_sequencer_if.slave (request, ALU drive/capture, response)
//     busy   : high whenever not IDLE
//   Optional feature macro: VSEC_BCAST_EN (adds bus.req_bcast; lane 0 of B
//   is replicated to every lane when sampled high at acceptance).
module vector_alu_sequencer #(
  parameter int WIDTH = 8,
  parameter int LANES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_alu_sequencer_if.slave bus,
  output logic                  busy
);
  localparam int CW = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  typedef struct packed {
    logic [1:0]                  op;
    logic [LANES-1:0][WIDTH-1:0] a;
    logic [LANES-1:0][WIDTH-1:0] b;
  } req_t;

  state_t                      state, state_nxt;
  req_t                        rq;
  logic [LANES-1:0][WIDTH-1:0] res;
  logic [LANES-1:0][WIDTH-1:0] b_in;
  logic [CW-1:0]               cnt;
  logic                        nacc, zacc, err;
  logic                        accept, illegal, last;

  assign accept  = bus.req_valid && bus.req_ready;
  assign illegal = (bus.req_op == 2'b10);
  assign last    = (cnt == CW'(LANES-1));

  // Broadcast is folded into the captured B so the issue path stays per-lane.
`ifdef VSEC_BCAST_EN
  always_comb begin
    b_in = bus.req_b;
    if (bus.req_bcast)
      for (int i = 0; i < LANES; i++) b_in[i] = bus.req_b[WIDTH-1:0];
  end
`else
  assign b_in = bus.req_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rq    <= '0;
      res   <= '0;
      cnt   <= '0;
      nacc  <= 1'b0;
      zacc  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (accept) begin
          rq.op <= bus.req_op;
          rq.a  <= bus.req_a;
          rq.b  <= b_in;
          res   <= '0;
          cnt   <= '0;
          err   <= illegal;
          nacc  <= 1'b0;
          // Illegal ops report flags 00, so Z must not start at 1 for them.
          zacc  <= !illegal;
        end
        ISSUE: begin
          res[cnt] <= bus.alu_result;
          nacc     <= nacc | bus.alu_flags[0];
          zacc     <= zacc & bus.alu_flags[1];
          cnt      <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state;
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_ctrl = 2'b00;
    case (state)
      IDLE:  if (accept) state_nxt = illegal ? RESP : ISSUE;
      ISSUE: begin
        bus.alu_a    = rq.a[cnt];
        bus.alu_b    = rq.b[cnt];
        bus.alu_ctrl = rq.op;
        if (last) state_nxt = RESP;
      end
      RESP:  if (bus.rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.req_ready  = (state == IDLE);
  assign bus.rsp_valid  = (state == RESP);
  assign busy           = (state != IDLE);
  assign bus.rsp_result = res;
  assign bus.rsp_flags  = {zacc, nacc};
  assign bus.rsp_err    = err;
endmodule
